seq_pattern_gen: RTL and testbench

- Serial test-pattern generator: the transmit side for the Mealy/Moore sequence detectors.
- Captures a pattern word and shifts it out MSB-first on one serial line, one bit per programmable bit period.
- Emits a per-bit strobe that can drive the detectors' input and clock-enable.
- Sits beside the detectors in the board-level demo, so on-chip stimulus replaces hand-toggled switches.

---
 rtl/seq_gen_pkg.sv | 19 +
 rtl/bit_tick_div.sv | 43 ++++
 rtl/seq_pattern_gen.sv | 123 ++++++++++++
 tb/tb_seq_pattern_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared state encoding and helpers for the serial test-pattern generator.
package seq_gen_pkg;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] SHIFT_ENC = 2'd1;
    localparam logic [1:0] DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        SHIFT = SHIFT_ENC,
        DONE  = DONE_ENC
    } state_t;

    // Requested lengths beyond the shadow register size send the whole word.
    function automatic int clamp_len(input int len, input int width);
        return (len > width) ? width : len;
    endfunction

endpackage

// File: rtl/bit_tick_div.sv
// Bit-period divider: counts DIV cycles per bit and raises a registered tick
// in the last cycle of each period.
module bit_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic load,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          tick_q, tick_d;

    // The tick flop looks at the next count so it lines up with div_cnt==DIV-1.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!run || load) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == CW'(DIV - 1)) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + CW'(1);
        end
        tick_d = run && (div_cnt_d == CW'(DIV - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial test-pattern generator: captures a word and shifts it out MSB-first,
// one bit per DIV cycles, optionally repeating until stopped.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DIV   = 4,
    localparam int LENW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             rep_en,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [LENW-1:0]  len_in,
    output logic             x_out,
    output logic             bit_stb,
    output logic             busy,
    output logic             done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [LENW-1:0]  idx_q, idx_d;
    logic [LENW-1:0]  len_q, len_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             div_run;
    logic             div_load;

    bit_tick_div #(
        .DIV (DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .run  (div_run),
        .load (div_load),
        .tick (tick)
    );

    // Outputs are derived from the next state so every output is a flop.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        shadow_d = shadow_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    shadow_d = pattern_in;
                    len_d    = LENW'(clamp_len(int'(len_in), WIDTH));
                    if (len_d == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                        idx_d   = len_d - LENW'(1);
                    end
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (idx_q == '0) begin
                        if (rep_en) begin
                            idx_d = len_q - LENW'(1);
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        idx_d = idx_q - LENW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop) begin
            state_d = IDLE;
        end

        div_run  = (state_d == SHIFT);
        div_load = (state_q != SHIFT);
        busy_d   = (state_d == SHIFT);
        done_d   = (state_d == DONE);
        x_d      = (state_d == SHIFT) ? shadow_d[idx_d[IW-1:0]] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            shadow_q <= '0;
            x_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            shadow_q <= shadow_d;
            x_q      <= x_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x_out   = x_q;
    assign bit_stb = tick;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: two instances (DIV=4 and DIV=1) share stimulus and
// are checked every cycle against a per-cycle output schedule model.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       rep_en = 1'b0;
    logic [7:0] pattern_in = 8'h00;
    logic [3:0] len_in = 4'd0;

    logic x4, stb4, busy4, done4;
    logic x1, stb1, busy1, done1;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    seq_pattern_gen #(.WIDTH(8), .DIV(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .rep_en(rep_en),
        .pattern_in(pattern_in), .len_in(len_in),
        .x_out(x4), .bit_stb(stb4), .busy(busy4), .done(done4)
    );

    seq_pattern_gen #(.WIDTH(8), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .rep_en(rep_en),
        .pattern_in(pattern_in), .len_in(len_in),
        .x_out(x1), .bit_stb(stb1), .busy(busy1), .done(done1)
    );

    typedef struct packed {
        logic x;
        logic stb;
        logic busy;
        logic done;
        logic last;
    } ent_t;

    // Model: a queue of the exact outputs expected in each upcoming cycle.
    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam int D = (g == 0) ? 4 : 1;
        ent_t       q[$];
        ent_t       cur = '0;
        logic [7:0] cap_pat = 8'h00;
        int         cap_len = 0;

        always @(posedge clk or negedge rst) begin
            ent_t       nxt;
            logic [7:0] p;
            int         l;
            bit         do_pass;
            bit         do_done;
            nxt = '0;
            p = cap_pat;
            l = cap_len;
            do_pass = 1'b0;
            do_done = 1'b0;
            if (!rst || stop) begin
                q.delete();
            end else begin
                if (cur.last) begin
                    if (rep_en) do_pass = 1'b1;
                    else        do_done = 1'b1;
                end else if (q.size() == 0 && !cur.busy && !cur.done && start) begin
                    p = pattern_in;
                    l = (len_in > 8) ? 8 : int'(len_in);
                    if (l == 0) do_done = 1'b1;
                    else        do_pass = 1'b1;
                end
                if (do_pass) begin
                    for (int b = l - 1; b >= 0; b--) begin
                        for (int c = 0; c < D; c++) begin
                            q.push_back('{x: p[b], stb: (c == D - 1), busy: 1'b1,
                                          done: 1'b0, last: (b == 0 && c == D - 1)});
                        end
                    end
                end
                if (do_done) begin
                    q.push_back('{x: 1'b0, stb: 1'b0, busy: 1'b0, done: 1'b1, last: 1'b0});
                end
                if (q.size() > 0) nxt = q.pop_front();
            end
            cap_pat <= p;
            cap_len <= l;
            cur     <= nxt;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking && rst) begin
            check_output("cycle_dut4", {28'd0, x4, stb4, busy4, done4},
                         {28'd0, mdl[0].cur.x, mdl[0].cur.stb, mdl[0].cur.busy, mdl[0].cur.done});
            check_output("cycle_dut1", {28'd0, x1, stb1, busy1, done1},
                         {28'd0, mdl[1].cur.x, mdl[1].cur.stb, mdl[1].cur.busy, mdl[1].cur.done});
        end
    end

    task automatic apply_stimulus(input logic [7:0] pat, input logic [3:0] len, input logic rep);
        @(negedge clk);
        pattern_in = pat;
        len_in = len;
        rep_en = rep;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pattern_in = ~pat;
        len_in = 4'd5;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy4 || done4 || busy1 || done1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("wait_idle", {28'd0, busy4, done4, busy1, done1}, 32'd0);
    endtask

    // Watches dut4 from cycle 1 after capture; includes a 1011 Mealy detector
    // clocked by bit_stb to emulate the loopback demo.
    task automatic observe_run(input int budget, output int stb_n, output logic [15:0] bits,
                               output logic [15:0] zmask, output int done_at, output int busy_n);
        logic [2:0] hist = 3'b000;
        stb_n = 0;
        bits = 16'h0;
        zmask = 16'h0;
        done_at = -1;
        busy_n = 0;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) @(negedge clk);
            if (stb4) begin
                stb_n++;
                bits = {bits[14:0], x4};
                if (hist == 3'b101 && x4 && stb_n <= 16) zmask[stb_n - 1] = 1'b1;
                hist = {hist[1:0], x4};
            end
            if (busy4) busy_n++;
            if (done4) begin
                done_at = c;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          sn, da, bn, dn;
        logic [15:0] bits, zm;
        logic [6:0]  xs, ss;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_dut4", {28'd0, x4, stb4, busy4, done4}, 32'd0);
        check_output("reset_dut1", {28'd0, x1, stb1, busy1, done1}, 32'd0);
        rst = 1'b1;
        checking = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic run 8'b1011_0010 len 8");
        apply_stimulus(8'hB2, 4'd8, 1'b0);
        observe_run(60, sn, bits, zm, da, bn);
        check_output("basic_bits", {16'd0, bits}, 32'h00B2);
        check_output("basic_stb_count", sn, 8);
        check_output("basic_done_cycle", da, 33);
        check_output("basic_busy_cycles", bn, 32);
        wait_idle();

        $display("[TB] short length 3");
        apply_stimulus(8'hAE, 4'd3, 1'b0);
        observe_run(60, sn, bits, zm, da, bn);
        check_output("len3_bits", {16'd0, bits}, 32'h0006);
        check_output("len3_stb_count", sn, 3);
        check_output("len3_done_cycle", da, 13);
        wait_idle();

        $display("[TB] zero length");
        apply_stimulus(8'hFF, 4'd0, 1'b0);
        observe_run(10, sn, bits, zm, da, bn);
        check_output("len0_stb_count", sn, 0);
        check_output("len0_done_cycle", da, 1);
        check_output("len0_busy_cycles", bn, 0);
        wait_idle();

        $display("[TB] length 9 clamps to 8");
        apply_stimulus(8'hB2, 4'd9, 1'b0);
        observe_run(60, sn, bits, zm, da, bn);
        check_output("len9_bits", {16'd0, bits}, 32'h00B2);
        check_output("len9_done_cycle", da, 33);
        wait_idle();

        $display("[TB] start re-asserted mid-run");
        apply_stimulus(8'hB2, 4'd8, 1'b0);
        fork
            observe_run(60, sn, bits, zm, da, bn);
            begin
                repeat (9) @(negedge clk);
                pattern_in = 8'h4D;
                len_in = 4'd5;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check_output("midstart_bits", {16'd0, bits}, 32'h00B2);
        check_output("midstart_done_cycle", da, 33);
        wait_idle();

        $display("[TB] start and stop together in idle");
        @(negedge clk);
        pattern_in = 8'hFF;
        len_in = 4'd8;
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        check_output("startstop_busy_c1", {30'd0, busy4, busy1}, 32'd0);
        @(negedge clk);
        check_output("startstop_busy_c2", {30'd0, busy4, busy1}, 32'd0);

        $display("[TB] repeat 3'b101 with stop at cycle 7");
        apply_stimulus(8'h05, 4'd3, 1'b1);
        xs = 7'd0;
        ss = 7'd0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            xs = {xs[5:0], x1};
            ss = {ss[5:0], stb1};
            if (c == 7) stop = 1'b1;
        end
        @(negedge clk);
        stop = 1'b0;
        rep_en = 1'b0;
        check_output("rep_x_stream", {25'd0, xs}, 32'h5B);
        check_output("rep_stb_stream", {25'd0, ss}, 32'h7F);
        check_output("stop_dut1_outputs", {28'd0, x1, stb1, busy1, done1}, 32'd0);
        check_output("stop_dut4_outputs", {28'd0, x4, stb4, busy4, done4}, 32'd0);
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            dn += int'(done4) + int'(done1);
        end
        check_output("stop_no_done", dn, 0);

        $display("[TB] repeat ended by dropping rep_en");
        apply_stimulus(8'h02, 4'd2, 1'b1);
        repeat (5) @(negedge clk);
        rep_en = 1'b0;
        wait_idle();

        $display("[TB] asynchronous reset mid-bit");
        apply_stimulus(8'hB2, 4'd8, 1'b0);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("async_rst_dut4", {28'd0, x4, stb4, busy4, done4}, 32'd0);
        check_output("async_rst_dut1", {28'd0, x1, stb1, busy1, done1}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        apply_stimulus(8'hAE, 4'd3, 1'b0);
        observe_run(60, sn, bits, zm, da, bn);
        check_output("post_rst_bits", {16'd0, bits}, 32'h0006);
        check_output("post_rst_done_cycle", da, 13);
        wait_idle();

        $display("[TB] loopback into 1011 Mealy detector");
        apply_stimulus(8'hBB, 4'd8, 1'b0);
        observe_run(60, sn, bits, zm, da, bn);
        check_output("loop_z_positions", {16'd0, zm}, 32'h0088);
        check_output("loop_stb_count", sn, 8);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
